// File: rtl/mem_periph_bus.sv
`default_nettype none
// ============================================================================
// Module   : mem_periph_bus
// Brief    : MEM-stage data bus: word RAM plus timer/LED/digit/systick regs.
//            Optional timer (TH/TL/TCON, irq) built when PERIPH_TIMER_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module mem_periph_bus #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits
);

  localparam int          c_IDX_W      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] c_RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [31:0] c_ADDR_TH    = 32'h4000_0000;
  localparam logic [31:0] c_ADDR_TL    = 32'h4000_0004;
  localparam logic [31:0] c_ADDR_TCON  = 32'h4000_0008;
  localparam logic [31:0] c_ADDR_LED   = 32'h4000_000C;
  localparam logic [31:0] c_ADDR_DIG   = 32'h4000_0010;
  localparam logic [31:0] c_ADDR_TICK  = 32'h4000_0014;

  logic [31:0]        r_ram [RAM_WORDS];
  logic [31:0]        r_systick;
  logic [7:0]         r_led;
  logic [11:0]        r_digits;
  logic               w_ram_sel;
  logic [c_IDX_W-1:0] w_ram_idx;
  logic [31:0]        w_th_q;
  logic [31:0]        w_tl_q;
  logic [2:0]         w_tcon_q;

  assign w_ram_sel = (address < c_RAM_BYTES);
  assign w_ram_idx = address[c_IDX_W+1:2];

  // RAM is never cleared; reset only blocks a same-cycle store.
  always_ff @(posedge clk) begin
    if (mem_write && w_ram_sel && !reset)
      r_ram[w_ram_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_systick <= '0;
      r_led     <= '0;
      r_digits  <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (mem_write && address == c_ADDR_LED)
        r_led <= write_data[7:0];
      if (mem_write && address == c_ADDR_DIG)
        r_digits <= write_data[11:0];
    end
  end

`ifdef PERIPH_TIMER_EN
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;

  assign w_wr_th   = mem_write && (address == c_ADDR_TH);
  assign w_wr_tl   = mem_write && (address == c_ADDR_TL);
  assign w_wr_tcon = mem_write && (address == c_ADDR_TCON);

  // Software writes are applied last so they win over the timer's own update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (r_tcon[0]) begin
        if (r_tl == 32'hFFFF_FFFF) begin
          r_tl <= r_th;
          if (r_tcon[1])
            r_tcon[2] <= 1'b1;
        end else begin
          r_tl <= r_tl + 32'd1;
        end
      end
      if (w_wr_th)
        r_th <= write_data;
      if (w_wr_tl)
        r_tl <= write_data;
      if (w_wr_tcon)
        r_tcon <= write_data[2:0];
    end
  end

  assign w_th_q   = r_th;
  assign w_tl_q   = r_tl;
  assign w_tcon_q = r_tcon;
  assign irq      = r_tcon[2];
`else
  assign w_th_q   = '0;
  assign w_tl_q   = '0;
  assign w_tcon_q = '0;
  assign irq      = 1'b0;
`endif

  // Load path is purely combinational and shows the pre-edge contents.
  always_comb begin
    read_data = '0;
    if (mem_read) begin
      if (w_ram_sel) begin
        read_data = r_ram[w_ram_idx];
      end else begin
        case (address)
          c_ADDR_TH:   read_data = w_th_q;
          c_ADDR_TL:   read_data = w_tl_q;
          c_ADDR_TCON: read_data = {29'd0, w_tcon_q};
          c_ADDR_LED:  read_data = {24'd0, r_led};
          c_ADDR_DIG:  read_data = {20'd0, r_digits};
          c_ADDR_TICK: read_data = r_systick;
          default:     read_data = '0;
        endcase
      end
    end
  end

  assign leds   = r_led;
  assign digits = r_digits;

endmodule
`default_nettype wire

// File: doc/mem_periph_bus.md
MEM_PERIPH_BUS -- requirements
Module: mem_periph_bus

Interface
REQ-001 SHALL have parameter: RAM_WORDS, 256, data RAM depth in 32-bit words (power of two, max 256).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: mem_read  input  1  MEM-stage load strobe.
REQ-005 SHALL have port: mem_write  input  1  MEM-stage store strobe.
REQ-006 SHALL have port: address  input  32  byte address from the EX/MEM ALU result.
REQ-007 SHALL have port: write_data  input  32  store data (rt).
REQ-008 SHALL have port: read_data  output  32  load data, combinational.
REQ-009 SHALL have port: irq  output  1  timer interrupt request, level, registered.
REQ-010 SHALL have port: leds  output  8  LED register.
REQ-011 SHALL have port: digits  output  12  seven-segment drive register.

Function
REQ-012 SHALL decode 0x00000000..(RAM_WORDS*4-1) as RAM, word index address[9:2]; address[1:0] ignored.
REQ-013 SHALL decode peripherals: 0x40000000 TH, 0x40000004 TL, 0x40000008 TCON[2:0], 0x4000000C LED[7:0], 0x40000010 DIGITS[11:0], 0x40000014 SYSTICK (read-only).
REQ-014 SHALL perform writes on the clk edge when mem_write=1; writes to unmapped or read-only addresses SHALL be ignored.
REQ-015 SHALL drive read_data combinationally in the same cycle: mapped value, zero-extended to 32 bits, when mem_read=1; 0 when mem_read=0 or address unmapped.
REQ-016 SHALL, with mem_read and mem_write both 1, perform the write at the edge; read_data SHALL show the pre-write value.
REQ-017 SHALL increment SYSTICK by 1 every cycle, wrapping 0xFFFFFFFF->0.
REQ-018 SHALL use TCON bit0 = timer enable, bit1 = interrupt enable, bit2 = interrupt status.
REQ-019 SHALL, when TCON[0]=1, increment TL each cycle; when TL=0xFFFFFFFF the next value SHALL be TH (reload) instead of 0.
REQ-020 SHALL set TCON[2] on the reload edge if TCON[1]=1; TCON[2] SHALL remain set until software writes TCON with bit2=0.
REQ-021 SHALL drive irq = TCON[2].
REQ-022 SHALL give a software write to TL or TCON priority over the same-cycle increment/reload/status-set.
REQ-023 SHALL leave TL frozen when TCON[0]=0.
REQ-024 SHALL drive leds = LED register and digits = DIGITS register directly.

Reset
REQ-025 SHALL clear TH, TL, TCON, LED, DIGITS, SYSTICK to 0 on reset; read_data SHALL follow REQ-015; irq, leds, digits SHALL be 0 the cycle after reset.
REQ-026 SHALL NOT clear RAM contents on reset.
REQ-027 SHALL let reset override any same-cycle write or timer event.

Configuration
REQ-028 SHALL honour macro PERIPH_TIMER_EN: defined -> TH/TL/TCON and irq behave per REQ-018..023; undefined -> timer registers absent, their addresses read 0 and ignore writes, irq tied 0.

Verification
REQ-029 SHALL cover: store 0xDEADBEEF to 0x00000010, load 0x00000013 next cycle -> read_data=0xDEADBEEF.
REQ-030 SHALL cover: write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 -> TL sequence FFFFFFFF, FFFFFFFC, FFFFFFFD; irq=1 from the reload edge and held.
REQ-031 SHALL cover: irq=1, write TCON=3 -> irq=0 next cycle; write TCON=0 -> TL holds value.
REQ-032 SHALL cover: load 0x40000020 or 0x00000400 (RAM_WORDS=256) -> read_data=0; store to 0x40000014 -> SYSTICK unchanged trend.
REQ-033 SHALL cover: write LED=0x1A5 then reset mid-count -> leds=0xA5 before, leds=0, SYSTICK=0, TL=0 after; RAM word retained.
REQ-034 SHALL cover: PERIPH_TIMER_EN undefined, write TCON=3 -> read 0x40000008 gives 0, irq stays 0.
